// File: rtl/angle_sweep_seq_pkg.sv
// Shared widths, limits and state encoding for the angle ROM sweep sequencer.
package angle_sweep_seq_pkg;

   localparam int ANG_W          = 32;
   localparam int ADDR_W         = 10;
   localparam int ANG_MAX        = 360;
   localparam int FETCH_TO_VALID = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      PRESENT = 2'd2,
      FINISH  = 2'd3
   } state_t;

endpackage

// File: rtl/angle_sweep_seq_if.sv
// ROM read port plus valid/ready angle stream between the sequencer and its neighbours.
interface angle_sweep_seq_if;
   import angle_sweep_seq_pkg::*;

   logic [ADDR_W-1:0] rom_addr;
   logic              rom_ce;
   logic              rom_rd;
   logic [ANG_W-1:0]  rom_data;

   logic [ANG_W-1:0]  ang_data;
   logic [ADDR_W-1:0] ang_idx;
   logic              ang_valid;
   logic              ang_ready;

   modport master (
      output rom_addr, rom_ce, rom_rd,
      input  rom_data,
      output ang_data, ang_idx, ang_valid,
      input  ang_ready
   );

   modport slave (
      input  rom_addr, rom_ce, rom_rd,
      output rom_data,
      input  ang_data, ang_idx, ang_valid,
      output ang_ready
   );

endinterface

// File: rtl/angle_sweep_seq.sv
// Walks the angle ROM from START_ANG to STOP_ANG in STEP increments and hands each
// registered word downstream over a valid/ready handshake, with abort and back-pressure.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; ROM disabled, nothing presented
// FETCH   | ROM read of addr_q; word captured into the output register
// PRESENT | word held valid until accepted; then next address or finish
// FINISH  | single-cycle done pulse, back to IDLE
module angle_sweep_seq
   import angle_sweep_seq_pkg::*;
#(
   parameter int START_ANG = 0,
   parameter int STOP_ANG  = 360,
   parameter int STEP      = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   angle_sweep_seq_if.master bus,
   output logic              busy,
   output logic              done
);

   if (START_ANG < 0 || START_ANG > STOP_ANG || STOP_ANG > ANG_MAX ||
       STEP < 1 || STEP > ANG_MAX) begin : g_param_check
      $fatal(1, "angle_sweep_seq: illegal START_ANG/STOP_ANG/STEP combination");
   end

   localparam logic [ADDR_W-1:0] START_Q = ADDR_W'(START_ANG);
   localparam logic [ADDR_W:0]   STOP_W  = (ADDR_W+1)'(STOP_ANG);
   localparam logic [ADDR_W:0]   STEP_W  = (ADDR_W+1)'(STEP);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ANG_W-1:0]  data_q;
   logic [ADDR_W-1:0] idx_q;
   logic              valid_q, valid_d;
   logic              load;
   logic              rom_en;
   logic [ADDR_W:0]   nxt;

   // one extra bit so an address past 360 compares correctly instead of wrapping
   assign nxt = {1'b0, addr_q} + STEP_W;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= START_Q;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         valid_q <= valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
         idx_q  <= '0;
      end else if (load) begin
         data_q <= bus.rom_data;
         idx_q  <= addr_q;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      valid_d = valid_q;
      load    = 1'b0;
      rom_en  = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               addr_d  = START_Q;
               state_d = FETCH;
            end
         end
         FETCH: begin
            rom_en = 1'b1;
            if (abort) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end else begin
               load    = 1'b1;
               valid_d = 1'b1;
               state_d = PRESENT;
            end
         end
         PRESENT: begin
            // abort wins over a same-edge accept: the word is treated as not transferred
            if (abort) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end else if (bus.ang_ready) begin
               valid_d = 1'b0;
               if (nxt <= STOP_W) begin
                  addr_d  = nxt[ADDR_W-1:0];
                  state_d = FETCH;
               end else begin
                  state_d = FINISH;
               end
            end
         end
         FINISH: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            valid_d = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   assign busy          = (state_q != IDLE);
   assign bus.rom_addr  = addr_q;
   assign bus.rom_ce    = rom_en;
   assign bus.rom_rd    = rom_en;
   assign bus.ang_data  = data_q;
   assign bus.ang_idx   = idx_q;
   assign bus.ang_valid = valid_q;

endmodule

// File: tb/tb_angle_sweep_seq.sv
// Self-checking bench: three sequencer configurations against an arithmetic sweep model.
`timescale 1ns/1ps
module tb_angle_sweep_seq;
   import angle_sweep_seq_pkg::*;

   localparam int NI = 3;

   typedef struct {
      int inst;
      int start_a;
      int stop_a;
      int step;
      int n_words;
      int last_word;
   } vec_t;

   vec_t vecs[NI];

   logic clk = 1'b0;
   logic rst;
   logic start[NI];
   logic abort[NI];
   logic ready[NI];
   logic busy[NI];
   logic done[NI];
   logic valid[NI];
   logic ce[NI];
   logic rd[NI];
   logic [9:0]  raddr[NI];
   logic [9:0]  idx[NI];
   logic [31:0] data[NI];

   int cfg_start[NI];
   int cfg_stop[NI];
   int cfg_step[NI];

   int acc[NI];
   int dones[NI];
   int last_acc[NI];
   int last_word[NI];
   bit gap_on[NI];
   bit hold_pending[NI];
   int hold_data[NI];
   int hold_idx[NI];

   int cyc = 0;
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   angle_sweep_seq_if b0();
   angle_sweep_seq_if b1();
   angle_sweep_seq_if b2();

   angle_sweep_seq #(.START_ANG(0), .STOP_ANG(360), .STEP(1)) u0 (
      .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]),
      .bus(b0), .busy(busy[0]), .done(done[0]));
   angle_sweep_seq #(.START_ANG(0), .STOP_ANG(360), .STEP(45)) u1 (
      .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]),
      .bus(b1), .busy(busy[1]), .done(done[1]));
   angle_sweep_seq #(.START_ANG(10), .STOP_ANG(300), .STEP(100)) u2 (
      .clk(clk), .rst(rst), .start(start[2]), .abort(abort[2]),
      .bus(b2), .busy(busy[2]), .done(done[2]));

   // ROM contents mem[k] = k
   assign b0.rom_data  = (b0.rom_ce && b0.rom_rd) ? 32'(b0.rom_addr) : 32'd0;
   assign b1.rom_data  = (b1.rom_ce && b1.rom_rd) ? 32'(b1.rom_addr) : 32'd0;
   assign b2.rom_data  = (b2.rom_ce && b2.rom_rd) ? 32'(b2.rom_addr) : 32'd0;
   assign b0.ang_ready = ready[0];
   assign b1.ang_ready = ready[1];
   assign b2.ang_ready = ready[2];

   assign valid[0] = b0.ang_valid; assign valid[1] = b1.ang_valid; assign valid[2] = b2.ang_valid;
   assign ce[0]    = b0.rom_ce;    assign ce[1]    = b1.rom_ce;    assign ce[2]    = b2.rom_ce;
   assign rd[0]    = b0.rom_rd;    assign rd[1]    = b1.rom_rd;    assign rd[2]    = b2.rom_rd;
   assign raddr[0] = b0.rom_addr;  assign raddr[1] = b1.rom_addr;  assign raddr[2] = b2.rom_addr;
   assign idx[0]   = b0.ang_idx;   assign idx[1]   = b1.ang_idx;   assign idx[2]   = b2.ang_idx;
   assign data[0]  = b0.ang_data;  assign data[1]  = b1.ang_data;  assign data[2]  = b2.ang_data;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // reference: the list of addresses a sweep visits, by plain enumeration
   function automatic int model_words(input int i);
      int n = 0;
      for (int a = cfg_start[i]; a <= cfg_stop[i]; a += cfg_step[i]) n++;
      return n;
   endfunction

   function automatic int model_word(input int i, input int k);
      return cfg_start[i] + k * cfg_step[i];
   endfunction

   task automatic arm(input int i);
      acc[i]          = 0;
      dones[i]        = 0;
      last_acc[i]     = -100;
      last_word[i]    = -1;
      hold_pending[i] = 1'b0;
   endtask

   task automatic monitor_all();
      for (int i = 0; i < NI; i++) begin
         int exp_w;
         exp_w = model_word(i, acc[i]);
         chk($sformatf("rom_addr_range_u%0d", i), int'(int'(raddr[i]) <= cfg_stop[i]), 1);
         if (ce[i]) begin
            chk($sformatf("fetch_addr_u%0d", i), int'(raddr[i]), exp_w);
            chk($sformatf("fetch_rd_u%0d", i), int'(rd[i]), 1);
         end
         if (valid[i] && hold_pending[i]) begin
            chk($sformatf("hold_data_u%0d", i), int'(data[i]), hold_data[i]);
            chk($sformatf("hold_idx_u%0d", i), int'(idx[i]), hold_idx[i]);
         end
         if (done[i]) begin
            dones[i]++;
            chk($sformatf("done_latency_u%0d", i), cyc - last_acc[i], 1);
            chk($sformatf("done_words_u%0d", i), acc[i], model_words(i));
         end
         if (valid[i] && ready[i] && !abort[i]) begin
            chk($sformatf("word_data_u%0d", i), int'(data[i]), exp_w);
            chk($sformatf("word_idx_u%0d", i), int'(idx[i]), exp_w);
            if (gap_on[i] && acc[i] > 0)
               chk($sformatf("word_gap_u%0d", i), cyc - last_acc[i], 2);
            acc[i]++;
            last_acc[i]     = cyc;
            last_word[i]    = int'(data[i]);
            hold_pending[i] = 1'b0;
         end else begin
            hold_pending[i] = valid[i];
            hold_data[i]    = int'(data[i]);
            hold_idx[i]     = int'(idx[i]);
         end
      end
   endtask

   // inputs change 1ns after a rising edge; outputs are observed on the falling edge
   task automatic tick();
      @(negedge clk);
      if (!rst) monitor_all();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic wait_done(input int i, input int budget);
      int n = 0;
      while (dones[i] == 0 && n < budget) begin
         tick();
         n++;
      end
      chk($sformatf("done_seen_u%0d", i), int'(dones[i] > 0), 1);
   endtask

   task automatic wait_word(input int i, input int w, input int budget);
      int n = 0;
      while (!(valid[i] && int'(idx[i]) == w) && n < budget) begin
         tick();
         n++;
      end
      chk($sformatf("word_%0d_reached_u%0d", w, i), int'(valid[i] && int'(idx[i]) == w), 1);
   endtask

   task automatic pulse_start(input int i);
      start[i] = 1'b1;
      tick();
      start[i] = 1'b0;
   endtask

   task automatic chk_reset_outputs(input int i);
      chk($sformatf("rst_valid_u%0d", i), int'(valid[i]), 0);
      chk($sformatf("rst_busy_u%0d", i), int'(busy[i]), 0);
      chk($sformatf("rst_done_u%0d", i), int'(done[i]), 0);
      chk($sformatf("rst_ce_u%0d", i), int'(ce[i]), 0);
      chk($sformatf("rst_rd_u%0d", i), int'(rd[i]), 0);
      chk($sformatf("rst_data_u%0d", i), int'(data[i]), 0);
      chk($sformatf("rst_idx_u%0d", i), int'(idx[i]), 0);
      chk($sformatf("rst_addr_u%0d", i), int'(raddr[i]), cfg_start[i]);
   endtask

   initial begin
      vecs[0] = '{inst: 0, start_a: 0,  stop_a: 360, step: 1,   n_words: 361, last_word: 360};
      vecs[1] = '{inst: 1, start_a: 0,  stop_a: 360, step: 45,  n_words: 9,   last_word: 360};
      vecs[2] = '{inst: 2, start_a: 10, stop_a: 300, step: 100, n_words: 3,   last_word: 210};
      for (int i = 0; i < NI; i++) begin
         cfg_start[i] = vecs[i].start_a;
         cfg_stop[i]  = vecs[i].stop_a;
         cfg_step[i]  = vecs[i].step;
         start[i]     = 1'b0;
         abort[i]     = 1'b0;
         ready[i]     = 1'b1;
         gap_on[i]    = 1'b0;
         arm(i);
      end
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) chk_reset_outputs(i);
      rst = 1'b0;
      tick();

      // table: full sweeps with ready held high
      for (int v = 0; v < NI; v++) begin
         int i;
         i = vecs[v].inst;
         arm(i);
         gap_on[i] = 1'b1;
         ready[i]  = 1'b1;
         pulse_start(i);
         chk($sformatf("start_fetch_u%0d", i), int'(ce[i]), 1);
         chk($sformatf("start_busy_u%0d", i), int'(busy[i]), 1);
         chk($sformatf("start_novalid_u%0d", i), int'(valid[i]), 0);
         repeat (FETCH_TO_VALID - 1) tick();
         chk($sformatf("valid_latency_u%0d", i), int'(valid[i]), 1);
         wait_done(i, 2 * vecs[v].n_words + 20);
         chk($sformatf("tbl_words_u%0d", i), acc[i], vecs[v].n_words);
         chk($sformatf("tbl_last_u%0d", i), last_word[i], vecs[v].last_word);
         chk($sformatf("tbl_busy_after_u%0d", i), int'(busy[i]), 0);
         repeat (3) tick();
         chk($sformatf("tbl_done_once_u%0d", i), dones[i], 1);
         gap_on[i] = 1'b0;
      end

      // random back-pressure on two instances at once
      arm(0);
      arm(1);
      start[0] = 1'b1;
      start[1] = 1'b1;
      tick();
      start[0] = 1'b0;
      start[1] = 1'b0;
      for (int n = 0; n < 4000 && (dones[0] == 0 || dones[1] == 0); n++) begin
         ready[0] = 1'($urandom_range(0, 1));
         ready[1] = 1'($urandom_range(0, 1));
         tick();
      end
      ready[0] = 1'b1;
      ready[1] = 1'b1;
      chk("rand_words_u0", acc[0], model_words(0));
      chk("rand_words_u1", acc[1], model_words(1));
      chk("rand_done_u0", dones[0], 1);
      chk("rand_done_u1", dones[1], 1);
      tick();

      // back-pressure held for 5 cycles on word 3
      arm(0);
      pulse_start(0);
      wait_word(0, 3, 20);
      ready[0] = 1'b0;
      for (int n = 0; n < 5; n++) begin
         tick();
         chk("bp_valid", int'(valid[0]), 1);
         chk("bp_data", int'(data[0]), 3);
         chk("bp_idx", int'(idx[0]), 3);
         chk("bp_ce", int'(ce[0]), 0);
      end
      ready[0] = 1'b1;
      wait_done(0, 800);
      chk("bp_words", acc[0], 361);
      chk("bp_done_once", dones[0], 1);
      tick();

      // abort on word 7 with ready high
      arm(0);
      pulse_start(0);
      wait_word(0, 7, 30);
      abort[0] = 1'b1;
      tick();
      abort[0] = 1'b0;
      chk("abort_valid", int'(valid[0]), 0);
      chk("abort_busy", int'(busy[0]), 0);
      chk("abort_done", int'(done[0]), 0);
      chk("abort_words", acc[0], 7);
      repeat (3) tick();
      chk("abort_no_done", dones[0], 0);
      start[0] = 1'b1;
      abort[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      abort[0] = 1'b0;
      chk("idle_abort_start_busy", int'(busy[0]), 0);
      tick();
      arm(0);
      pulse_start(0);
      chk("restart_addr", int'(raddr[0]), 0);
      wait_done(0, 800);
      chk("restart_words", acc[0], 361);

      // reset in FETCH, then a stray start while busy
      arm(1);
      pulse_start(1);
      for (int n = 0; n < 20 && !(ce[1] && int'(raddr[1]) == 90); n++) tick();
      chk("rst_reach_fetch", int'(ce[1] && int'(raddr[1]) == 90), 1);
      rst = 1'b1;
      tick();
      chk_reset_outputs(1);
      rst = 1'b0;
      arm(1);
      tick();
      chk("rst_no_done", dones[1], 0);
      pulse_start(1);
      wait_word(1, 135, 20);
      start[1] = 1'b1;
      tick();
      start[1] = 1'b0;
      wait_done(1, 40);
      chk("busy_start_words", acc[1], 9);
      chk("busy_start_last", last_word[1], 360);
      repeat (4) tick();
      chk("busy_start_done_once", dones[1], 1);
      chk("busy_start_idle", int'(busy[1]), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
